// File: rtl/dsm_input_stage.sv
// dsm_input_stage: the front end of the delta-sigma modulator.
// It accepts PCM samples over a valid/ready handshake and queues one sample ahead.
// It holds the current sample for OSR modulator ticks and generates the tick and
// frame strobes. It drives (held sample - feedback DAC level) to the first integrator.
// Optional feature: define DSM_INPUT_DITHER_EN to add a 16-bit LFSR LSB
// (seed 16'hACE1, advanced once per tick) as dither on o_data.
module dsm_input_stage #(
  parameter int DATA_WIDTH = 3,
  parameter int OUT_WIDTH  = 4,
  parameter int OSR        = 16,
  parameter int DIV        = 4,
  parameter int FB_LEVEL   = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                        i_fb,
  output logic                        o_sample,
  output logic                        o_frame,
  output logic signed [OUT_WIDTH-1:0] o_data,
  output logic                        o_underrun,
  input  logic                        i_clr_underrun
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OCW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [OCW-1:0] OSR_LAST = OCW'(OSR - 1);
  localparam logic signed [OUT_WIDTH-1:0] FB_POS = OUT_WIDTH'(FB_LEVEL);
  localparam logic signed [OUT_WIDTH-1:0] FB_NEG = -FB_POS;

  if (OSR < 2) begin : g_osr_check
    $error("dsm_input_stage: OSR must be >= 2");
  end
  if (DIV < 2) begin : g_div_check
    $error("dsm_input_stage: DIV must be >= 2");
  end
  // Largest positive result (max sample + FB_LEVEL + dither 1) must fit in OUT_WIDTH.
  if ((2 ** (OUT_WIDTH - 1)) < ((2 ** (DATA_WIDTH - 1)) + FB_LEVEL + 1)) begin : g_width_check
    $error("dsm_input_stage: OUT_WIDTH too small for DATA_WIDTH and FB_LEVEL");
  end

  logic [DCW-1:0]                div_cnt;
  logic [OCW-1:0]                osr_cnt;
  logic signed [DATA_WIDTH-1:0]  cur;
  logic signed [DATA_WIDTH-1:0]  nxt;
  logic                          next_full;
  logic                          tick;
  logic                          frame;
  logic                          accept;
  logic signed [OUT_WIDTH-1:0]   cur_ext;
  logic signed [OUT_WIDTH-1:0]   fb_sel;
  logic signed [OUT_WIDTH-1:0]   dith;
  logic signed [OUT_WIDTH-1:0]   diff;

  assign o_ready = !next_full;

  // Decode the tick, the frame boundary and the handshake accept.
  always_comb begin
    tick   = 1'b0;
    frame  = 1'b0;
    accept = 1'b0;
    tick   = i_en && (div_cnt == DIV_LAST);
    frame  = tick && (osr_cnt == OSR_LAST);
    accept = i_valid && !next_full;
  end

  // Tick and frame counters with registered strobes; they freeze while i_en is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt  <= '0;
      osr_cnt  <= '0;
      o_sample <= 1'b0;
      o_frame  <= 1'b0;
    end else begin
      o_sample <= tick;
      o_frame  <= frame;
      if (i_en) begin
        if (tick) begin
          div_cnt <= '0;
          osr_cnt <= (osr_cnt == OSR_LAST) ? '0 : osr_cnt + OCW'(1);
        end else begin
          div_cnt <= div_cnt + DCW'(1);
        end
      end
    end
  end

  // One-entry queue feeding the held sample; it promotes the queued sample at the frame boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur       <= '0;
      nxt       <= '0;
      next_full <= 1'b0;
    end else if (frame && next_full) begin
      cur       <= nxt;
      next_full <= 1'b0;
    end else if (accept) begin
      nxt       <= i_data;
      next_full <= 1'b1;
    end
  end

  // Sticky underrun: a boundary with nothing queued sets it, and the set wins over a clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_underrun <= 1'b0;
    end else if (frame && !next_full) begin
      o_underrun <= 1'b1;
    end else if (i_clr_underrun) begin
      o_underrun <= 1'b0;
    end
  end

`ifdef DSM_INPUT_DITHER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Fibonacci LFSR (taps 16,14,13,11) stepped once per modulator tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr <= 16'hACE1;
    end else if (tick) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  assign dith = {{(OUT_WIDTH-1){1'b0}}, lfsr[0]};
`else
  assign dith = '0;
`endif

  // Sign-extend the held sample and subtract the feedback DAC level. The width check guarantees no wrap.
  always_comb begin
    cur_ext = '0;
    fb_sel  = '0;
    diff    = '0;
    cur_ext = {{(OUT_WIDTH-DATA_WIDTH){cur[DATA_WIDTH-1]}}, cur};
    fb_sel  = i_fb ? FB_POS : FB_NEG;
    diff    = cur_ext - fb_sel + dith;
  end

  // Register the difference every cycle for the integrator input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
    end else begin
      o_data <= diff;
    end
  end

endmodule

// File: tb/tb_dsm_input_stage.sv
// Testbench for dsm_input_stage. It uses a cycle model plus a scoreboard queue of accepted samples.
module tb_dsm_input_stage;
  localparam int DATA_WIDTH = 3;
  localparam int OUT_WIDTH  = 4;
  localparam int OSR        = 16;
  localparam int DIV        = 4;
  localparam int FB_LEVEL   = 3;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_en = 1'b0;
  logic i_valid = 1'b0;
  logic i_fb = 1'b0;
  logic i_clr_underrun = 1'b0;
  logic signed [DATA_WIDTH-1:0] i_data = '0;
  logic o_ready, o_sample, o_frame, o_underrun;
  logic signed [OUT_WIDTH-1:0] o_data;

  int checks = 0;
  int errors = 0;

  // model state
  int m_div = 0;
  int m_osr = 0;
  logic signed [DATA_WIDTH-1:0] exp_q[$];
  logic signed [DATA_WIDTH-1:0] exp_cur = '0;
  logic exp_sample = 1'b0;
  logic exp_frame = 1'b0;
  logic exp_under = 1'b0;
  logic exp_dith = 1'b0;
  logic pre_bound = 1'b0;
  logic signed [OUT_WIDTH-1:0] exp_data = '0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic m_rdy, m_tk, m_bd, m_set;
  int m_fbv;
  logic signed [OUT_WIDTH-1:0] want;

  dsm_input_stage #(
    .DATA_WIDTH(DATA_WIDTH), .OUT_WIDTH(OUT_WIDTH), .OSR(OSR), .DIV(DIV), .FB_LEVEL(FB_LEVEL)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_fb(i_fb), .o_sample(o_sample), .o_frame(o_frame), .o_data(o_data),
    .o_underrun(o_underrun), .i_clr_underrun(i_clr_underrun)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: updated on every active edge from the inputs the bench drives.
  initial forever begin
    @(posedge i_clk or negedge i_rst_n);
    if (!i_rst_n) begin
      m_div = 0; m_osr = 0; exp_q.delete(); exp_cur = '0;
      exp_sample = 1'b0; exp_frame = 1'b0; exp_under = 1'b0;
      exp_data = '0; exp_dith = 1'b0; m_lfsr = 16'hACE1; pre_bound = 1'b0;
    end else begin
      m_rdy = (exp_q.size() == 0);
      m_tk  = i_en && (m_div == DIV - 1);
      m_bd  = m_tk && (m_osr == OSR - 1);
      m_fbv = i_fb ? FB_LEVEL : -FB_LEVEL;
      exp_dith = 1'b0;
`ifdef DSM_INPUT_DITHER_EN
      exp_dith = m_lfsr[0];
      if (m_tk) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
      exp_data = OUT_WIDTH'(int'(exp_cur) - m_fbv + int'({1'b0, exp_dith}));
      if (m_tk) begin
        m_div = 0;
        m_osr = m_bd ? 0 : m_osr + 1;
      end else if (i_en) begin
        m_div = m_div + 1;
      end
      exp_sample = m_tk;
      exp_frame  = m_bd;
      m_set = m_bd && (exp_q.size() == 0);
      if (m_bd && exp_q.size() > 0) exp_cur = exp_q.pop_front();
      if (m_set) exp_under = 1'b1;
      else if (i_clr_underrun) exp_under = 1'b0;
      if (i_valid && m_rdy) exp_q.push_back(i_data);
      pre_bound = i_en && (m_div == DIV - 1) && (m_osr == OSR - 1);
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_boundary(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!exp_frame && n < 200);
    checks++;
    if (o_frame !== 1'b1) begin
      errors++;
      $display("FAIL %s_frame: o_frame=%b required 1 (cycles=%0d)", tag, o_frame, n);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) step();
    checks++; if (o_data !== 4'sd0) begin errors++; $display("FAIL reset_data: got %0d want 0", o_data); end
    checks++; if (o_sample !== 1'b0) begin errors++; $display("FAIL reset_sample: got %b want 0", o_sample); end
    checks++; if (o_frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b want 0", o_frame); end
    checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", o_underrun); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
  endtask

  task automatic test_strobe();
    int ns, nf, first, n;
    ns = 0; nf = 0; first = -1;
    i_en = 1'b1; i_fb = 1'b1;
    i_rst_n = 1'b1;
    for (int c = 1; c <= 128; c++) begin
      step();
      checks++;
      if (o_sample !== exp_sample || o_frame !== exp_frame) begin
        errors++;
        $display("FAIL strobe_c%0d: sample=%b frame=%b want %b %b", c, o_sample, o_frame, exp_sample, exp_frame);
      end
      if (o_sample === 1'b1) begin ns++; if (first < 0) first = c; end
      if (o_frame === 1'b1) nf++;
    end
    checks++; if (first != DIV) begin errors++; $display("FAIL strobe_first: at %0d want %0d", first, DIV); end
    checks++; if (ns != 32) begin errors++; $display("FAIL strobe_count: got %0d want 32", ns); end
    checks++; if (nf != 2) begin errors++; $display("FAIL frame_count: got %0d want 2", nf); end
    checks++; if (o_underrun !== 1'b1) begin errors++; $display("FAIL strobe_underrun: got %b want 1", o_underrun); end
    checks++; if (o_data !== -4'sd3) begin errors++; $display("FAIL strobe_data: got %0d want -3", o_data); end
    i_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (o_sample !== 1'b0) begin errors++; $display("FAIL en_low_sample%0d: got %b want 0", c, o_sample); end
    end
    i_en = 1'b1;
    n = 0;
    do begin step(); n++; end while (o_sample !== 1'b1 && n < 20);
    checks++; if (n != DIV) begin errors++; $display("FAIL en_resume: first tick after %0d want %0d", n, DIV); end
    for (int c = 0; c < 12; c++) begin
      step();
      checks++;
      if (o_sample !== exp_sample || o_frame !== exp_frame) begin
        errors++;
        $display("FAIL resume_c%0d: sample=%b frame=%b want %b %b", c, o_sample, o_frame, exp_sample, exp_frame);
      end
    end
  endtask

  task automatic test_arith();
    logic signed [DATA_WIDTH-1:0] smp [2];
    int pos [2];
    int neg [2];
    smp[0] = 3'sd3;  pos[0] = 0;  neg[0] = 6;
    smp[1] = -3'sd4; pos[1] = -7; neg[1] = -1;
    for (int k = 0; k < 2; k++) begin
      i_data = smp[k]; i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL arith_queue%0d: ready=%b want 0", k, o_ready); end
      wait_boundary("arith");
      i_fb = 1'b1;
      step();
      want = OUT_WIDTH'(pos[k] + int'({1'b0, exp_dith}));
      checks++; if (o_data !== want) begin errors++; $display("FAIL arith_fb1_%0d: got %0d want %0d", k, o_data, want); end
      i_fb = 1'b0;
      step();
      want = OUT_WIDTH'(neg[k] + int'({1'b0, exp_dith}));
      checks++; if (o_data !== want) begin errors++; $display("FAIL arith_fb0_%0d: got %0d want %0d", k, o_data, want); end
      checks++; if (o_data !== exp_data) begin errors++; $display("FAIL arith_model%0d: got %0d want %0d", k, o_data, exp_data); end
    end
  endtask

  task automatic test_back_to_back();
    i_fb = 1'b1;
    repeat (3) step();
    i_data = 3'sd1; i_valid = 1'b1;
    step();
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_first: ready=%b want 0", o_ready); end
    i_data = 3'sd2;
    step();
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: ready=%b want 0", o_ready); end
    wait_boundary("bp");
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_boundary_ready: ready=%b want 1", o_ready); end
    step();
    i_valid = 1'b0;
    want = OUT_WIDTH'(-2 + int'({1'b0, exp_dith}));
    checks++; if (o_data !== want) begin errors++; $display("FAIL bp_cur1: got %0d want %0d", o_data, want); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: ready=%b want 0", o_ready); end
    wait_boundary("bp2");
    step();
    want = OUT_WIDTH'(-1 + int'({1'b0, exp_dith}));
    checks++; if (o_data !== want) begin errors++; $display("FAIL bp_cur2: got %0d want %0d", o_data, want); end
  endtask

  task automatic test_underrun();
    int n;
    checks++; if (o_underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b want 1", o_underrun); end
    i_clr_underrun = 1'b1;
    step();
    i_clr_underrun = 1'b0;
    checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b want 0", o_underrun); end
    wait_boundary("ur");
    checks++; if (o_underrun !== 1'b1) begin errors++; $display("FAIL ur_set: got %b want 1", o_underrun); end
    step();
    want = OUT_WIDTH'(-1 + int'({1'b0, exp_dith}));
    checks++; if (o_data !== want) begin errors++; $display("FAIL ur_repeat: got %0d want %0d", o_data, want); end
    i_clr_underrun = 1'b1;
    step();
    i_clr_underrun = 1'b0;
    checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL ur_clear2: got %b want 0", o_underrun); end
    n = 0;
    while (!pre_bound && n < 200) begin step(); n++; end
    i_clr_underrun = 1'b1; i_valid = 1'b1; i_data = 3'sd1;
    step();
    i_clr_underrun = 1'b0; i_valid = 1'b0;
    checks++; if (o_frame !== 1'b1) begin errors++; $display("FAIL ur_coincide_frame: got %b want 1", o_frame); end
    checks++; if (o_underrun !== 1'b1) begin errors++; $display("FAIL ur_set_wins: got %b want 1", o_underrun); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL ur_boundary_accept: ready=%b want 0", o_ready); end
    wait_boundary("ur2");
    step();
    want = OUT_WIDTH'(-2 + int'({1'b0, exp_dith}));
    checks++; if (o_data !== want) begin errors++; $display("FAIL ur_promote: got %0d want %0d", o_data, want); end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (5) step();
    i_data = 3'sd3; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rm_queued: ready=%b want 0", o_ready); end
    step();
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", o_ready); end
    checks++; if (o_data !== 4'sd0) begin errors++; $display("FAIL rm_data: got %0d want 0", o_data); end
    checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL rm_underrun: got %b want 0", o_underrun); end
    checks++; if (o_sample !== 1'b0 || o_frame !== 1'b0) begin errors++; $display("FAIL rm_strobes: %b %b want 0 0", o_sample, o_frame); end
    repeat (2) step();
    i_rst_n = 1'b1;
    n = 0;
    do begin step(); n++; end while (o_sample !== 1'b1 && n < 20);
    checks++; if (n != DIV) begin errors++; $display("FAIL rm_first_tick: after %0d want %0d", n, DIV); end
    want = OUT_WIDTH'(-3 + int'({1'b0, exp_dith}));
    checks++; if (o_data !== want) begin errors++; $display("FAIL rm_discard: got %0d want %0d", o_data, want); end
    while (o_frame !== 1'b1 && n < 200) begin step(); n++; end
    checks++; if (n != DIV * OSR) begin errors++; $display("FAIL rm_frame_restart: after %0d want %0d", n, DIV * OSR); end
    step();
    checks++; if (o_underrun !== 1'b1) begin errors++; $display("FAIL rm_underrun_after: got %b want 1", o_underrun); end
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_arith();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
